// File: rtl/lfsr_ring_pkg.sv
// Shared constants for the lfsr_ring_gen sequence generator:
// mode encodings and default tap/reset values for WIDTH=4.
package lfsr_ring_pkg;

   localparam logic [1:0] MODE_RING    = 2'b00;
   localparam logic [1:0] MODE_JOHNSON = 2'b01;
   localparam logic [1:0] MODE_LFSR    = 2'b10;
   localparam logic [1:0] MODE_HOLD    = 2'b11;

   localparam logic [3:0] DEF_TAPS      = 4'b0011;
   localparam logic [3:0] DEF_RESET_VAL = 4'b0001;

endpackage

// File: rtl/lfsr_ring_next.sv
// Combinational next-state for lfsr_ring_gen: right shift with a
// mode-selected bit inserted at the MSB (ring, Johnson, LFSR, hold).
module lfsr_ring_next
   import lfsr_ring_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] next_o,
   output logic             fb_o
);

   always_comb begin
      fb_o   = q_i[0];
      next_o = q_i;
      unique case (mode_i)
         MODE_RING:    fb_o = q_i[0];
         MODE_JOHNSON: fb_o = ~q_i[0];
         MODE_LFSR:    fb_o = ^(q_i & TAPS);
         default:      fb_o = q_i[0];
      endcase
      if (mode_i != MODE_HOLD)
         next_o = {fb_o, q_i[WIDTH-1:1]};
   end

endmodule

// File: rtl/lfsr_ring_gen.sv
// Ring/Johnson/LFSR sequence generator with seed load, wrap and lockup.
// Define LFSR_RING_GEN_RECOVER_EN to auto-escape the LFSR all-zero state.
module lfsr_ring_gen
   import lfsr_ring_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             lockup
);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] step_val;
   logic             fb_unused;
   logic             zero_lfsr;
   logic             recover;
   logic             step;

   lfsr_ring_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_next (
      .q_i    (q_q),
      .mode_i (mode),
      .next_o (nxt),
      .fb_o   (fb_unused)
   );

   assign zero_lfsr = (mode == MODE_LFSR) && (q_q == '0);
   assign step      = en && !load && (mode != MODE_HOLD);

`ifdef LFSR_RING_GEN_RECOVER_EN
   assign recover  = zero_lfsr;
   assign step_val = recover ? {{(WIDTH-1){1'b0}}, 1'b1} : nxt;
`else
   assign recover  = 1'b0;
   assign step_val = nxt;
`endif

   always_comb begin
      q_d    = q_q;
      ref_d  = ref_q;
      wrap_d = 1'b0;
      if (load) begin
         q_d   = seed;
         ref_d = seed;
      end else if (step) begin
         q_d    = step_val;
         wrap_d = (step_val == ref_q) && !recover;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q    <= RESET_VAL;
         ref_q  <= RESET_VAL;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         ref_q  <= ref_d;
         wrap_q <= wrap_d;
      end
   end

   assign out    = q_q;
   assign wrap   = wrap_q;
   assign lockup = zero_lfsr;

endmodule

// File: doc/lfsr_ring_gen.md
Name: lfsr_ring_gen

Overview:
Parametrised shift-register sequence generator; the next generation of the team's 4-bit XOR-feedback ring counter.
- Generalised to WIDTH bits with a parameter tap mask.
- Adds runtime-selectable ring, Johnson and LFSR modes, step enable and synchronous seed load.
- Adds period-wrap detection and all-zero lock-up detection.
- Feeds test-pattern, scrambler-seed and round-robin pointer logic.

Parameters:
WIDTH, 4, state width in bits, WIDTH >= 2.
TAPS, 4'b0011, LFSR feedback mask over state bits; feedback = XOR-reduce(state & TAPS).
RESET_VAL, 4'b0001, state loaded on reset and initial wrap reference value.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  advance one step this cycle.
load  input  1  synchronous seed load, priority over en.
seed  input  WIDTH  value captured on load.
mode  input  2  00 ring, 01 Johnson, 10 LFSR, 11 hold.
out  output  WIDTH  current state.
wrap  output  1  one-cycle pulse, state returned to reference value.
lockup  output  1  LFSR mode with all-zero state.

Behaviour:
- Reset values: out=RESET_VAL, ref=RESET_VAL, wrap=0. lockup is 0 after reset, since RESET_VAL is nonzero (required).
- Reset asserted mid-operation overrides everything immediately; no step occurs on the deasserting edge.
- Registered state is Q; shifting is always rightward (LSB out, new bit into MSB).
- Next-state per mode:
  - ring: {Q[0], Q[WIDTH-1:1]}
  - Johnson: {~Q[0], Q[WIDTH-1:1]}
  - LFSR: {^(Q & TAPS), Q[WIDTH-1:1]}
  - hold: Q
- Priority each edge: reset > load > en > hold.
- load=1: Q<=seed; ref<=seed; wrap<=0. en is ignored that cycle.
- en=1, load=0, mode!=11: Q<=next. wrap<=(next==ref), so wrap is high in the same cycle out shows ref.
- Any other case: Q unchanged, wrap<=0.
- Latency: a step or load is visible on out one cycle after the sampling edge.
- mode is sampled every cycle. A change applies to the next step, and ref is not altered.
- lockup is combinational: (mode==10) && (Q==0).
- Seed 0 in ring or Johnson mode is legal. Ring mode then holds 0 and wraps every step. Johnson mode runs its normal 2*WIDTH cycle.
- An illegal Johnson seed (not a contiguous pattern) simply circulates; no error is flagged.

Optional Feature:
Macro LFSR_RING_GEN_RECOVER_EN.
- Defined: in LFSR mode with Q==0 and en=1, the next state is forced to 1 (LSB set) and wrap is not asserted. lockup is asserted only in the cycle where Q==0.
- Undefined: the all-zero state is stuck. lockup stays high until load, reset or a mode change.

Decomposition:
- Shared package lfsr_ring_pkg holds the mode encoding constants (MODE_RING=2'b00, MODE_JOHNSON=2'b01, MODE_LFSR=2'b10, MODE_HOLD=2'b11) and the default tap mask constant for WIDTH=4.
- One natural combinational sub-module: lfsr_ring_next (Q, mode -> next, feedback bit).
- State, ref, wrap and lockup logic stay in the top module.

Test Plan:
- Reset, then release with mode=10, en=1 (defaults) -> out is 0001, 1000, 0100, 0010, 1001, 1100, ... Returns to 0001 after exactly 15 steps, with wrap high only in that cycle.
- load=1, seed=0001, mode=00, en=1, then load=0 -> out is 1000, 0100, 0010, 0001. wrap pulses on the 4th step; load and en together in the load cycle perform the load only.
- load seed=0000, mode=01 -> out is 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. wrap fires on the 8th step.
- load seed=0000, mode=10 -> lockup=1.
  - With macro defined: the next en step gives out=0001 and lockup=0.
  - Without macro: out stays 0000 and lockup stays 1 for 10 cycles.
- LFSR run, en toggled 1/0, mode switched to 11 mid-sequence -> out frozen during en=0 and mode=11, wrap=0 throughout. The sequence resumes from the frozen value.
- Assert reset asynchronously mid-cycle during stepping -> out=0001 and wrap=0 immediately, before the next clk edge. ref is restored to 0001.
